// File: rtl/gain_ramp_ctrl.sv
// Gain sequencer for gain_core: moves the gain one step per sample strobe toward the
// requested target, with ramps for mute and for bypass entry and exit.
module gain_ramp_ctrl #(
  parameter int GWIDTH = 16,
  parameter int FBITS  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     bypass_i,
  input  logic                     mute_i,
  input  logic [GWIDTH-1:0]        step_i,
  input  logic                     tgt_valid,
  input  logic signed [GWIDTH-1:0] tgt_data,
  output logic                     tgt_ready,
  output logic signed [GWIDTH-1:0] gain_o,
  output logic                     en_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int                       UNITY_INT = 1 << FBITS;
  localparam logic signed [GWIDTH-1:0] UNITY     = UNITY_INT[GWIDTH-1:0];

  typedef enum logic [1:0] {
    ST_BYP,
    ST_RAMP,
    ST_HOLD,
    ST_EXIT
  } state_e;

  state_e                   state_q, state_d;
  logic signed [GWIDTH-1:0] cur_q, cur_d;
  logic signed [GWIDTH-1:0] tgt_q, tgt_d;
  logic                     done_q, done_d;

  logic [GWIDTH-1:0]        step_eff;
  logic signed [GWIDTH-1:0] eff_tgt;
  logic signed [GWIDTH-1:0] next_to_eff;
  logic signed [GWIDTH-1:0] next_to_unity;
  logic                     wr_accept;

  // One step from src toward dst. The move lands on dst whenever the remaining
  // distance fits in a step, so the result always lies between src and dst.
  function automatic logic signed [GWIDTH-1:0] step_toward(
    input logic signed [GWIDTH-1:0] src,
    input logic signed [GWIDTH-1:0] dst,
    input logic [GWIDTH-1:0]        step
  );
    logic signed [GWIDTH:0] diff;
    logic [GWIDTH:0]        mag;
    logic signed [GWIDTH:0] moved;
    diff = {dst[GWIDTH-1], dst} - {src[GWIDTH-1], src};
    mag  = diff[GWIDTH] ? -diff : diff;
    if (mag <= {1'b0, step}) begin
      return dst;
    end
    if (diff[GWIDTH]) begin
      moved = {src[GWIDTH-1], src} - {1'b0, step};
    end else begin
      moved = {src[GWIDTH-1], src} + {1'b0, step};
    end
    return moved[GWIDTH-1:0];
  endfunction

  always_comb begin
    step_eff      = (step_i == '0) ? GWIDTH'(1) : step_i;
    eff_tgt       = mute_i ? '0 : tgt_q;
    next_to_eff   = ce ? step_toward(cur_q, eff_tgt, step_eff) : cur_q;
    next_to_unity = ce ? step_toward(cur_q, UNITY, step_eff) : cur_q;
  end

  assign tgt_ready = (state_q == ST_HOLD) || (state_q == ST_BYP);
  assign wr_accept = tgt_valid && tgt_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = wr_accept ? tgt_data : tgt_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_BYP: begin
        cur_d = UNITY;
        if (!bypass_i) begin
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        cur_d = next_to_eff;
        // Arrival is tested every cycle, so a mute change can finish a ramp without ce.
        if (bypass_i) begin
          state_d = ST_EXIT;
        end else if (next_to_eff == eff_tgt) begin
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bypass_i) begin
          state_d = ST_EXIT;
        end else if (cur_q != eff_tgt) begin
          state_d = ST_RAMP;
        end
      end
      ST_EXIT: begin
        cur_d = next_to_unity;
        if (!bypass_i) begin
          state_d = ST_RAMP;
        end else if (next_to_unity == UNITY) begin
          state_d = ST_BYP;
        end
      end
      default: begin
        state_d = ST_BYP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_BYP;
      cur_q   <= UNITY;
      tgt_q   <= UNITY;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  // en drops on the same edge that lands the gain on unity and enters BYP.
  assign en_o   = (state_q != ST_BYP);
  assign busy_o = (state_q == ST_RAMP) || (state_q == ST_EXIT);
  assign done_o = done_q;
  assign gain_o = cur_q;

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Scoreboard bench for gain_ramp_ctrl: stimulus queues the expected sequence of output
// states, the monitor compares each observed change and the strobes since the last one.
module tb_gain_ramp_ctrl;

  localparam int GWIDTH = 16;
  localparam int FBITS  = 12;
  localparam int DC     = -1;

  typedef struct {
    string                    tag;
    logic signed [GWIDTH-1:0] gain;
    logic                     en;
    logic                     busy;
    logic                     done;
    logic                     ready;
    int                       dce;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ce;
  logic                     bypass_i;
  logic                     mute_i;
  logic [GWIDTH-1:0]        step_i;
  logic                     tgt_valid;
  logic signed [GWIDTH-1:0] tgt_data;
  logic                     tgt_ready;
  logic signed [GWIDTH-1:0] gain_o;
  logic                     en_o;
  logic                     busy_o;
  logic                     done_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ce_cnt = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce) ce_cnt <= ce_cnt + 1;
  end

  gain_ramp_ctrl #(.GWIDTH(GWIDTH), .FBITS(FBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .bypass_i  (bypass_i),
    .mute_i    (mute_i),
    .step_i    (step_i),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .gain_o    (gain_o),
    .en_o      (en_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  task automatic push(input string tag, input int g, input bit en, input bit busy,
                      input bit done, input bit ready, input int dce);
    exp_t e;
    e.tag   = tag;
    e.gain  = g[GWIDTH-1:0];
    e.en    = en;
    e.busy  = busy;
    e.done  = done;
    e.ready = ready;
    e.dce   = dce;
    exp_q.push_back(e);
  endtask

  // nsteps strobes from start by stp, the last one landing on target with done.
  task automatic exp_ramp(input string tag, input int start, input int stp,
                          input int nsteps, input int target);
    for (int k = 1; k < nsteps; k++) push(tag, start + k * stp, 1, 1, 0, 0, 1);
    push({tag, "_done"}, target, 1, 0, 1, 1, 1);
    push({tag, "_hold"}, target, 1, 0, 0, 1, DC);
  endtask

  task automatic edge_ce(input bit c);
    ce = c;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) edge_ce(1'b0);
  endtask

  task automatic strobes(input int n);
    repeat (n) edge_ce(1'b1);
  endtask

  task automatic strobes_gap(input int n);
    repeat (n) begin
      edge_ce(1'b0);
      edge_ce(1'b1);
    end
  endtask

  task automatic write(input int d);
    tgt_valid = 1'b1;
    tgt_data  = d[GWIDTH-1:0];
    edge_ce(1'b0);
    tgt_valid = 1'b0;
  endtask

  initial begin : monitor
    logic signed [GWIDTH-1:0] p_gain;
    logic p_en, p_busy, p_done, p_ready;
    bit   have_prev;
    int   ce_last;
    int   dce;
    exp_t e;
    bit   ok;
    have_prev = 1'b0;
    ce_last   = 0;
    p_gain    = '0;
    {p_en, p_busy, p_done, p_ready} = 4'b0;
    forever begin
      @(negedge clk);
      if (mon_en && (!have_prev || gain_o !== p_gain || en_o !== p_en || busy_o !== p_busy ||
                     done_o !== p_done || tgt_ready !== p_ready)) begin
        dce = ce_cnt - ce_last;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got gain=%0d en=%0b busy=%0b done=%0b ready=%0b, want no change",
                   gain_o, en_o, busy_o, done_o, tgt_ready);
        end else begin
          e  = exp_q.pop_front();
          ok = (gain_o === e.gain) && (en_o === e.en) && (busy_o === e.busy) &&
               (done_o === e.done) && (tgt_ready === e.ready) && (e.dce < 0 || dce == e.dce);
          if (!ok) begin
            errors++;
            $display("FAIL %s: got gain=%0d en=%0b busy=%0b done=%0b ready=%0b strobes=%0d, want gain=%0d en=%0b busy=%0b done=%0b ready=%0b strobes=%0d",
                     e.tag, gain_o, en_o, busy_o, done_o, tgt_ready, dce,
                     e.gain, e.en, e.busy, e.done, e.ready, e.dce);
          end
        end
        have_prev = 1'b1;
        p_gain    = gain_o;
        p_en      = en_o;
        p_busy    = busy_o;
        p_done    = done_o;
        p_ready   = tgt_ready;
        ce_last   = ce_cnt;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst       = 1'b1;
    ce        = 1'b0;
    bypass_i  = 1'b1;
    mute_i    = 1'b0;
    step_i    = 16'd256;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 4096, 0, 0, 0, 1, DC);
    mon_en = 1'b1;
    rst    = 1'b0;
    idle(2);

    // Leave bypass with the reset target of unity: straight to HOLD.
    push("byp_exit", 4096, 1, 1, 0, 0, DC);
    push("byp_exit_done", 4096, 1, 0, 1, 1, DC);
    push("byp_exit_hold", 4096, 1, 0, 0, 1, DC);
    bypass_i = 1'b0;
    idle(4);

    // Non-divisible step with strobes on alternate cycles.
    step_i = 16'd64;
    push("nondiv_entry", 4096, 1, 1, 0, 0, DC);
    exp_ramp("nondiv", 4096, 64, 2, 4196);
    write(4196);
    idle(1);
    strobes_gap(2);
    idle(2);

    // Step 0 behaves as step 1.
    step_i = 16'd0;
    push("step0_entry", 4196, 1, 1, 0, 0, DC);
    exp_ramp("step0", 4196, 1, 2, 4198);
    write(4198);
    idle(1);
    strobes_gap(2);
    idle(2);

    // Distance within one step lands in a single strobe.
    step_i = 16'd256;
    push("onestep_entry", 4198, 1, 1, 0, 0, DC);
    exp_ramp("onestep", 4198, 0, 1, 4096);
    write(4096);
    idle(1);
    strobes(1);
    idle(2);

    // Mute, released halfway: ramp turns back toward 4096.
    step_i = 16'd1024;
    push("mute_entry", 4096, 1, 1, 0, 0, DC);
    push("mute_dn", 3072, 1, 1, 0, 0, 1);
    push("mute_dn", 2048, 1, 1, 0, 0, 1);
    push("unmute_up", 3072, 1, 1, 0, 0, 1);
    push("unmute_done", 4096, 1, 0, 1, 1, 1);
    push("unmute_hold", 4096, 1, 0, 0, 1, DC);
    mute_i = 1'b1;
    idle(1);
    strobes(2);
    mute_i = 1'b0;
    idle(1);
    strobes(2);
    idle(2);

    // Full mute: 4 strobes to 0.
    push("mute_full_entry", 4096, 1, 1, 0, 0, DC);
    exp_ramp("mute_full", 4096, -1024, 4, 0);
    mute_i = 1'b1;
    idle(1);
    strobes(4);
    idle(2);

    // Unmute then re-mute before any strobe: RAMP ends with no ce.
    push("blip_entry", 0, 1, 1, 0, 0, DC);
    push("blip_done", 0, 1, 0, 1, 1, 0);
    push("blip_hold", 0, 1, 0, 0, 1, DC);
    mute_i = 1'b0;
    idle(1);
    mute_i = 1'b1;
    idle(3);

    push("unmute_entry", 0, 1, 1, 0, 0, DC);
    exp_ramp("unmute", 0, 1024, 4, 4096);
    mute_i = 1'b0;
    idle(1);
    strobes(4);
    idle(2);

    // Target ramp 4096 -> 8192 in 16 strobes of 256.
    step_i = 16'd256;
    push("tgt_entry", 4096, 1, 1, 0, 0, DC);
    exp_ramp("tgt_ramp", 4096, 256, 16, 8192);
    write(8192);
    idle(1);
    strobes(16);
    idle(2);

    // Bypass entry from 8192: en drops with the final step to unity.
    push("exit_entry", 8192, 1, 1, 0, 0, DC);
    for (int k = 1; k < 16; k++) push("exit_dn", 8192 - 256 * k, 1, 1, 0, 0, 1);
    push("exit_byp", 4096, 0, 0, 0, 1, 1);
    bypass_i = 1'b1;
    idle(1);
    strobes(16);
    idle(2);

    // Bypass exit resumes toward the stored 8192.
    push("reenter_entry", 4096, 1, 1, 0, 0, DC);
    exp_ramp("reenter", 4096, 256, 16, 8192);
    bypass_i = 1'b0;
    idle(1);
    strobes(16);
    idle(2);

    // Bypass with mute also high: EXIT still heads for unity.
    step_i = 16'd1024;
    push("exit2_entry", 8192, 1, 1, 0, 0, DC);
    push("exit2_dn", 7168, 1, 1, 0, 0, 1);
    push("exit2_dn", 6144, 1, 1, 0, 0, 1);
    push("exit2_dn", 5120, 1, 1, 0, 0, 1);
    push("exit2_byp", 4096, 0, 0, 0, 1, 1);
    bypass_i = 1'b1;
    mute_i   = 1'b1;
    idle(1);
    strobes(4);
    idle(2);
    mute_i = 1'b0;

    // Write in BYP is held until bypass exit; en stays low meanwhile.
    write(2048);
    idle(2);
    step_i = 16'd256;
    push("bypwr_entry", 4096, 1, 1, 0, 0, DC);
    exp_ramp("bypwr", 4096, -256, 8, 2048);
    bypass_i = 1'b0;
    idle(1);
    strobes(8);
    idle(2);

    // Reset mid-ramp; afterwards the target is unity again.
    push("rstmid_entry", 2048, 1, 1, 0, 0, DC);
    push("rstmid_up", 2304, 1, 1, 0, 0, 1);
    push("rstmid_up", 2560, 1, 1, 0, 0, 1);
    push("rstmid_up", 2816, 1, 1, 0, 0, 1);
    push("rst", 4096, 0, 0, 0, 1, DC);
    push("rst_reenter", 4096, 1, 1, 0, 0, DC);
    push("rst_reenter_done", 4096, 1, 0, 1, 1, DC);
    push("rst_reenter_hold", 4096, 1, 0, 0, 1, DC);
    write(8192);
    idle(1);
    strobes(3);
    rst = 1'b1;
    edge_ce(1'b1);
    idle(1);
    rst = 1'b0;
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected outputs never seen (first %s), want 0",
               exp_q.size(), exp_q[0].tag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gain_ramp_ctrl.md
# gain_ramp_ctrl

Gain sequencer that sits in front of `gain_core` and drives its `data_gain` and `en` inputs. It keeps gain changes from producing audible zipper noise by ramping the gain linearly, one step per sample strobe, toward a requested target. It also handles mute (ramp to zero) and bypass entry and exit, ramping to unity gain before `en` drops and starting from unity gain when `en` rises. Target updates use a valid/ready handshake, and a new target is accepted only when no ramp is in progress.

## Interface
- `GWIDTH`, 16: gain width, signed fixed-point; must match `gain_core`.
- `FBITS`, 12: fractional bits. `UNITY = 1 << FBITS` (4096 at the default).

- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  sample strobe, the same strobe fed to `gain_core`. Ramp steps advance only on cycles with `ce` high.
- `bypass_i`  in  1  level. 1 requests bypass, 0 requests gain mode.
- `mute_i`  in  1  level. 1 forces the effective target to 0; ignored in bypass.
- `step_i`  in  GWIDTH  unsigned ramp step per `ce`. A value of 0 is treated as 1.
- `tgt_valid`  in  1  target write request.
- `tgt_data`  in  GWIDTH  signed target gain.
- `tgt_ready`  out  1  write accepted on a cycle where `tgt_valid && tgt_ready`.
- `gain_o`  out  GWIDTH  signed current gain; connects to `gain_core.data_gain`.
- `en_o`  out  1  connects to `gain_core.en`.
- `busy_o`  out  1  high while a ramp is in progress.
- `done_o`  out  1  one-cycle pulse when a gain-mode ramp reaches its target.

## Operation
- **Registers:** `cur` (drives `gain_o`), `tgt`, and the state register.
- **Effective target:** `T = mute_i ? 0 : tgt`.
- **Step rule:** applied only when `ce` is high.
  - Compute `diff = T - cur` at GWIDTH+1 bits, signed.
  - If `|diff| <= step`, then `cur <= T`.
  - Otherwise `cur <= cur + step` when `diff > 0`, or `cur <= cur - step` when `diff < 0`.
  - The ramp never overshoots, so no saturation is needed. Negative gains are legal.
- **States:** BYP, RAMP, HOLD, EXIT.
  - BYP: `en_o=0`, `cur=UNITY`. If `bypass_i==0`, go to RAMP with `en_o=1`.
  - RAMP: step toward `T`. If `bypass_i==1`, go to EXIT; this takes priority. Else if the next `cur` equals `T`, go to HOLD and pulse `done_o`. The comparison is made every cycle, so a mute toggle that makes `cur==T` exits RAMP without waiting for `ce`.
  - HOLD: if `bypass_i==1`, go to EXIT. Else if `cur != T` (after a new target write or a mute change), go to RAMP.
  - EXIT: step toward UNITY, ignoring `mute_i` and `tgt`. If `bypass_i==0`, go to RAMP. Else if the next `cur` equals UNITY, go to BYP with `en_o=0` at the same edge.
- **Handshake:**
  - `tgt_ready = (state==HOLD) || (state==BYP)`, decoded combinationally from the state.
  - A write accepted in BYP is stored and applied on bypass exit.
  - A write equal to `cur` in HOLD leaves the state in HOLD with no `done_o` pulse.
- **Outputs:** `busy_o = (state==RAMP) || (state==EXIT)`.

## Timing
- **Reset:** state=BYP, `cur=UNITY`, `tgt=UNITY`, `en_o=0`, `done_o=0`. Consequently `gain_o=4096`, `busy_o=0`, and `tgt_ready=1`.
- `rst` asserted at any point, including mid-ramp, returns everything to reset values at the next edge. Nothing is retained.
- **Bypass exit:** `en_o` rises on the edge after `bypass_i` is sampled low in BYP, with `gain_o=UNITY`. The first step happens on the first `ce` after that edge.
- **Target write:** a write accepted at edge k sets `tgt` at edge k. The state becomes RAMP at edge k+1, and `tgt_ready` is low from then on.
- **Ramp duration:** a ramp of distance D takes `ceil(D/step)` `ce` strobes. `done_o` is high for exactly the one cycle after the final step edge.
- **Bypass entry:** on the final step edge of EXIT, `gain_o=UNITY` and `en_o=0` are registered simultaneously.
- **Simultaneous events:**
  - `bypass_i` beats `mute_i` and beats target writes.
  - Mute changes during a ramp redirect it immediately toward the new `T`.

## Test plan
- **Target ramp:** from HOLD at 4096 with `step_i=256`, write 8192. Expect 16 `ce` strobes of +256 to reach 8192, then `done_o` for 1 cycle. `tgt_ready` is low during the ramp and high after.
- **Non-divisible step:** `cur=4096`, `step_i=64`, target 4196. Expect `gain_o` to go 4160 then 4196, with no overshoot. With `step_i=0`, 4096→4098 takes 2 strobes.
- **Mute:** in HOLD at 4096 with `step_i=1024`, raise `mute_i`. Expect 4 strobes to reach 0. Drop mute after 2 strobes (`cur=2048`) and expect the ramp to return to 4096 in 2 strobes.
- **Bypass cycle:** at 8192 with `step_i=256`, raise `bypass_i`. Expect 16 strobes down to 4096, with `en_o=0` on the same edge as the last step. Lower `bypass_i` and expect `en_o=1` with `gain_o=4096`, then a ramp to the stored target.
- **Write in BYP:** a write of 2048 in BYP is accepted and `en_o` stays 0. On bypass exit, expect a ramp from 4096 to 2048.
- **Reset mid-ramp:** assert `rst` partway through a ramp. Expect the next edge to give `gain_o=4096`, `en_o=0`, `busy_o=0`, and `tgt_ready=1`.
